// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: MEM/WB pipeline results take priority, and mul/div results
// wait in a small FIFO with age-based stall escalation. Optional macro: WB_ARB_BYPASS_EN.
module wb_port_arbiter #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wb_reg_write_in,
    input  logic                     wb_memory_to_register_in,
    input  logic                     wb_overflow_flag_in,
    input  logic [31:0]              wb_memory_data_in,
    input  logic [31:0]              wb_alu_result_in,
    input  logic [4:0]               wb_register_destination_in,
    input  logic                     md_valid_in,
    output logic                     md_ready_out,
    input  logic [31:0]              md_result_in,
    input  logic [4:0]               md_register_destination_in,
    output logic                     rf_write_enable_out,
    output logic [4:0]               rf_write_address_out,
    output logic [31:0]              rf_write_data_out,
    output logic                     stall_request_out,
    output logic                     overflow_exception_out,
    output logic [$clog2(DEPTH):0]   fifo_count_out
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int AGW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0]  FULL_COUNT = CW'(DEPTH);
    localparam logic [AGW-1:0] AGE_MAX    = AGW'(MAX_WAIT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_STARVE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_next;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AGW-1:0]  r_age;
    logic [AGW-1:0]  w_age_next;
    logic [31:0]     r_mem_data [DEPTH];
    logic [4:0]      r_mem_dest [DEPTH];
    logic            w_pipe_valid;
    logic [31:0]     w_pipe_data;
    logic            w_empty;
    logic            w_accept;
    logic            w_bypass;
    logic            w_push;
    logic            w_pop;

    assign w_pipe_valid = wb_reg_write_in & ~wb_overflow_flag_in &
                          (wb_register_destination_in != 5'd0);
    assign w_pipe_data  = wb_memory_to_register_in ? wb_memory_data_in : wb_alu_result_in;
    assign w_empty      = (r_count == {CW{1'b0}});
    assign md_ready_out = (r_count < FULL_COUNT);
    assign w_accept     = md_valid_in & md_ready_out;

`ifdef WB_ARB_BYPASS_EN
    assign w_bypass = w_accept & (md_register_destination_in != 5'd0) & w_empty & ~w_pipe_valid;
`else
    assign w_bypass = 1'b0;
`endif

    // Results addressed to r0 are accepted but silently dropped.
    assign w_push       = w_accept & (md_register_destination_in != 5'd0) & ~w_bypass;
    assign w_pop        = ~w_pipe_valid & ~w_empty;
    assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);
    assign fifo_count_out = r_count;

    // Head age: cleared when empty or popped, otherwise counts up and saturates.
    always_comb begin
        w_age_next = {AGW{1'b0}};
        if (w_empty || w_pop) begin
            w_age_next = {AGW{1'b0}};
        end else if (r_age == AGE_MAX) begin
            w_age_next = AGE_MAX;
        end else begin
            w_age_next = r_age + AGW'(1);
        end
    end

    // Next-state logic for the drain/starvation state machine.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_push) begin
                    w_state_next = ST_DRAIN;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (w_count_next == {CW{1'b0}}) begin
                    w_state_next = ST_IDLE;
                end else if (w_age_next == AGE_MAX) begin
                    w_state_next = ST_STARVE;
                end else begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_STARVE: begin
                if (w_pop) begin
                    w_state_next = (w_count_next == {CW{1'b0}}) ? ST_IDLE : ST_DRAIN;
                end else begin
                    w_state_next = ST_STARVE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // FIFO control state: pointers, occupancy, head age and FSM state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_count  <= {CW{1'b0}};
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_age    <= {AGW{1'b0}};
        end else begin
            r_state  <= w_state_next;
            r_count  <= w_count_next;
            r_age    <= w_age_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
        end
    end

    // FIFO storage; contents are qualified by the pointers, so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= md_result_in;
            r_mem_dest[r_wr_ptr] <= md_register_destination_in;
        end
    end

    // Registered write port, stall request and overflow pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_write_enable_out    <= 1'b0;
            rf_write_address_out   <= 5'd0;
            rf_write_data_out      <= 32'd0;
            stall_request_out      <= 1'b0;
            overflow_exception_out <= 1'b0;
        end else begin
            overflow_exception_out <= wb_reg_write_in & wb_overflow_flag_in;
            stall_request_out      <= (w_state_next == ST_STARVE);
            if (w_pipe_valid) begin
                rf_write_enable_out  <= 1'b1;
                rf_write_address_out <= wb_register_destination_in;
                rf_write_data_out    <= w_pipe_data;
            end else if (w_pop) begin
                rf_write_enable_out  <= 1'b1;
                rf_write_address_out <= r_mem_dest[r_rd_ptr];
                rf_write_data_out    <= r_mem_data[r_rd_ptr];
            end else if (w_bypass) begin
                rf_write_enable_out  <= 1'b1;
                rf_write_address_out <= md_register_destination_in;
                rf_write_data_out    <= md_result_in;
            end else begin
                rf_write_enable_out  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_wb_port_arbiter;

    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_reg_write_in, wb_memory_to_register_in, wb_overflow_flag_in;
    logic [31:0] wb_memory_data_in, wb_alu_result_in;
    logic [4:0]  wb_register_destination_in;
    logic        md_valid_in, md_ready_out;
    logic [31:0] md_result_in;
    logic [4:0]  md_register_destination_in;
    logic        rf_write_enable_out;
    logic [4:0]  rf_write_address_out;
    logic [31:0] rf_write_data_out;
    logic        stall_request_out, overflow_exception_out;
    logic [2:0]  fifo_count_out;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [4:0]  dest;
        logic [31:0] data;
    } md_ent_t;

    md_ent_t     exp_q[$];
    int          exp_age;
    logic        exp_we, exp_stall, exp_ovf, exp_ready, obs_ready;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;

    wb_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_reg_write_in(wb_reg_write_in),
        .wb_memory_to_register_in(wb_memory_to_register_in),
        .wb_overflow_flag_in(wb_overflow_flag_in),
        .wb_memory_data_in(wb_memory_data_in),
        .wb_alu_result_in(wb_alu_result_in),
        .wb_register_destination_in(wb_register_destination_in),
        .md_valid_in(md_valid_in), .md_ready_out(md_ready_out),
        .md_result_in(md_result_in),
        .md_register_destination_in(md_register_destination_in),
        .rf_write_enable_out(rf_write_enable_out),
        .rf_write_address_out(rf_write_address_out),
        .rf_write_data_out(rf_write_data_out),
        .stall_request_out(stall_request_out),
        .overflow_exception_out(overflow_exception_out),
        .fifo_count_out(fifo_count_out)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        exp_q.delete();
        exp_age   = 0;
        exp_we    = 1'b0;
        exp_addr  = 5'd0;
        exp_data  = 32'd0;
        exp_stall = 1'b0;
        exp_ovf   = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the reference model, then sample 1 time unit after the edge.
    task automatic step(input logic wr, input logic m2r, input logic ovf,
                        input logic [31:0] mdat, input logic [31:0] alu, input logic [4:0] wd,
                        input logic mv, input logic [31:0] mres, input logic [4:0] mdst);
        logic    pipe, acc, byp, was_empty, popped;
        md_ent_t ent;
        wb_reg_write_in            = wr;
        wb_memory_to_register_in   = m2r;
        wb_overflow_flag_in        = ovf;
        wb_memory_data_in          = mdat;
        wb_alu_result_in           = alu;
        wb_register_destination_in = wd;
        md_valid_in                = mv;
        md_result_in               = mres;
        md_register_destination_in = mdst;
        obs_ready = md_ready_out;
        exp_ready = (exp_q.size() < DEPTH);
        pipe      = wr && !ovf && (wd != 5'd0);
        acc       = mv && exp_ready;
        byp       = 1'b0;
`ifdef WB_ARB_BYPASS_EN
        byp = acc && (mdst != 5'd0) && (exp_q.size() == 0) && !pipe;
`endif
        was_empty = (exp_q.size() == 0);
        popped    = 1'b0;
        if (pipe) begin
            exp_we = 1'b1; exp_addr = wd; exp_data = m2r ? mdat : alu;
        end else if (!was_empty) begin
            ent = exp_q.pop_front();
            popped = 1'b1;
            exp_we = 1'b1; exp_addr = ent.dest; exp_data = ent.data;
        end else if (byp) begin
            exp_we = 1'b1; exp_addr = mdst; exp_data = mres;
        end else begin
            exp_we = 1'b0;
        end
        if (acc && (mdst != 5'd0) && !byp) begin
            ent.dest = mdst; ent.data = mres;
            exp_q.push_back(ent);
        end
        if (was_empty || popped) exp_age = 0;
        else if (exp_age < MAX_WAIT) exp_age = exp_age + 1;
        exp_stall = (exp_q.size() != 0) && (exp_age == MAX_WAIT);
        exp_ovf   = wr && ovf;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0, 5'd0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        wb_reg_write_in = 1'b0; wb_memory_to_register_in = 1'b0; wb_overflow_flag_in = 1'b0;
        wb_memory_data_in = 32'd0; wb_alu_result_in = 32'd0; wb_register_destination_in = 5'd0;
        md_valid_in = 1'b0; md_result_in = 32'd0; md_register_destination_in = 5'd0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if ({rf_write_enable_out, rf_write_address_out, rf_write_data_out, stall_request_out,
             overflow_exception_out, fifo_count_out} !== 41'd0) begin
            errors++;
            $display("FAIL reset_outputs: got we=%b addr=%0d data=%h stall=%b ovf=%b cnt=%0d, want all 0",
                     rf_write_enable_out, rf_write_address_out, rf_write_data_out,
                     stall_request_out, overflow_exception_out, fifo_count_out);
        end
        checks++;
        if (md_ready_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b, want 1", md_ready_out);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle();
            checks++;
            if (rf_write_enable_out !== 1'b0) begin
                errors++;
                $display("FAIL idle_no_write: got we=%b, want 0", rf_write_enable_out);
            end
        end
    endtask

    task automatic test_pipeline_write();
        step(1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 32'h1234_5678, 5'd5, 1'b0, 32'd0, 5'd0);
        checks++;
        if ({rf_write_enable_out, rf_write_address_out, rf_write_data_out} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL pipe_mem_write: got we=%b addr=%0d data=%h, want 1/5/deadbeef",
                     rf_write_enable_out, rf_write_address_out, rf_write_data_out);
        end
        step(1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0BAD_F00D, 5'd9, 1'b0, 32'd0, 5'd0);
        checks++;
        if ({rf_write_enable_out, rf_write_address_out, rf_write_data_out} !== {1'b1, 5'd9, 32'h0BAD_F00D}) begin
            errors++;
            $display("FAIL pipe_alu_write: got we=%b addr=%0d data=%h, want 1/9/0badf00d",
                     rf_write_enable_out, rf_write_address_out, rf_write_data_out);
        end
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'h5555_5555, 5'd0, 1'b0, 32'd0, 5'd0);
        checks++;
        if (rf_write_enable_out !== 1'b0) begin
            errors++;
            $display("FAIL pipe_r0_write: got we=%b, want 0", rf_write_enable_out);
        end
    endtask

    task automatic test_overflow();
        step(1'b1, 1'b0, 1'b1, 32'd0, 32'h7FFF_FFFF, 5'd7, 1'b0, 32'd0, 5'd0);
        checks++;
        if ({rf_write_enable_out, overflow_exception_out} !== 2'b01) begin
            errors++;
            $display("FAIL overflow_pulse: got we=%b ovf=%b, want we=0 ovf=1",
                     rf_write_enable_out, overflow_exception_out);
        end
        idle();
        checks++;
        if (overflow_exception_out !== 1'b0) begin
            errors++;
            $display("FAIL overflow_one_cycle: got ovf=%b, want 0", overflow_exception_out);
        end
    endtask

    task automatic test_fill_drain();
        logic [31:0] vals [4];
        for (int i = 0; i < 4; i++) begin
            vals[i] = $urandom;
            step(1'b1, 1'b0, 1'b0, 32'd0, $urandom, 5'(20 + i), 1'b1, vals[i], 5'(i + 1));
        end
        checks++;
        if ({fifo_count_out, md_ready_out} !== {3'd4, 1'b0}) begin
            errors++;
            $display("FAIL fill_full: got cnt=%0d ready=%b, want 4/0", fifo_count_out, md_ready_out);
        end
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd1, 5'd30, 1'b1, 32'hFFFF_0000, 5'd31);
        checks++;
        if (fifo_count_out !== 3'd4) begin
            errors++;
            $display("FAIL full_refuses_push: got cnt=%0d, want 4", fifo_count_out);
        end
        for (int i = 0; i < 4; i++) begin
            idle();
            checks++;
            if ({rf_write_enable_out, rf_write_address_out, rf_write_data_out} !== {1'b1, 5'(i + 1), vals[i]}) begin
                errors++;
                $display("FAIL drain_order[%0d]: got we=%b addr=%0d data=%h, want 1/%0d/%h",
                         i, rf_write_enable_out, rf_write_address_out, rf_write_data_out, i + 1, vals[i]);
            end
        end
        checks++;
        if (fifo_count_out !== 3'd0) begin
            errors++;
            $display("FAIL drain_empty: got cnt=%0d, want 0", fifo_count_out);
        end
    endtask

    task automatic test_starvation();
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd100, 5'd3, 1'b1, 32'hCAFE_0017, 5'd17);
        for (int k = 1; k <= MAX_WAIT + 1; k++) begin
            step(1'b1, 1'b0, 1'b0, 32'd0, 32'(k), 5'd3, 1'b0, 32'd0, 5'd0);
            checks++;
            if (stall_request_out !== (k >= MAX_WAIT)) begin
                errors++;
                $display("FAIL starve_wait[%0d]: got stall=%b, want %b", k, stall_request_out, k >= MAX_WAIT);
            end
        end
        idle();
        checks++;
        if ({rf_write_enable_out, rf_write_address_out, rf_write_data_out, stall_request_out}
            !== {1'b1, 5'd17, 32'hCAFE_0017, 1'b0}) begin
            errors++;
            $display("FAIL starve_release: got we=%b addr=%0d data=%h stall=%b, want 1/17/cafe0017/0",
                     rf_write_enable_out, rf_write_address_out, rf_write_data_out, stall_request_out);
        end
    endtask

    task automatic test_random();
        logic        wr, ovf, mv;
        logic [4:0]  wd, md;
        for (int n = 0; n < 600; n++) begin
            wr  = ($urandom_range(0, 99) < 60);
            ovf = ($urandom_range(0, 99) < 8);
            wd  = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            mv  = ($urandom_range(0, 99) < 45);
            md  = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            step(wr, 1'($urandom), ovf, $urandom, $urandom, wd, mv, $urandom, md);
            checks++;
            if (obs_ready !== exp_ready) begin
                errors++;
                $display("FAIL rand_ready[%0d]: got %b, want %b", n, obs_ready, exp_ready);
            end
            checks++;
            if ({rf_write_enable_out, rf_write_address_out, rf_write_data_out} !== {exp_we, exp_addr, exp_data}) begin
                errors++;
                $display("FAIL rand_write[%0d]: got %b/%0d/%h, want %b/%0d/%h", n, rf_write_enable_out,
                         rf_write_address_out, rf_write_data_out, exp_we, exp_addr, exp_data);
            end
            checks++;
            if ({fifo_count_out, stall_request_out, overflow_exception_out}
                !== {3'(exp_q.size()), exp_stall, exp_ovf}) begin
                errors++;
                $display("FAIL rand_status[%0d]: got cnt=%0d stall=%b ovf=%b, want %0d/%b/%b", n,
                         fifo_count_out, stall_request_out, overflow_exception_out,
                         exp_q.size(), exp_stall, exp_ovf);
            end
        end
        repeat (DEPTH + 1) idle();
        checks++;
        if (fifo_count_out !== 3'd0) begin
            errors++;
            $display("FAIL rand_drain: got cnt=%0d, want 0", fifo_count_out);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'd0, 32'd7, 5'd2, 1'b1, 32'(i + 50), 5'(i + 10));
        end
        checks++;
        if (fifo_count_out !== 3'd3) begin
            errors++;
            $display("FAIL mid_reset_prefill: got cnt=%0d, want 3", fifo_count_out);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({fifo_count_out, rf_write_enable_out, stall_request_out} !== {3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset_async: got cnt=%0d we=%b stall=%b, want 0/0/0",
                     fifo_count_out, rf_write_enable_out, stall_request_out);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            idle();
            checks++;
            if ({rf_write_enable_out, fifo_count_out} !== {1'b0, 3'd0}) begin
                errors++;
                $display("FAIL mid_reset_stale[%0d]: got we=%b cnt=%0d, want 0/0",
                         i, rf_write_enable_out, fifo_count_out);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pipeline_write();
        test_overflow();
        test_fill_drain();
        test_starvation();
        test_random();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
